// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The WIDTH-bit add is split into BLOCK-bit lookahead groups, resolved K groups per stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 8,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int K    = NBLK / STAGES;
    localparam int LAST = STAGES - 1;

    // Handshake: a beat moves on a side when valid & ready are both high at the
    // rising edge. The whole pipe advances together (adv), so in_ready = adv and
    // bubbles travel along with real beats rather than being squeezed out.
    logic adv;

    // Stage registers
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Per-stage inputs (stage 0 from ports, others from the previous register)
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
    logic             st_sub [STAGES];

    // Per-stage results
    logic [WIDTH-1:0] nx_sum [STAGES];
    logic             nx_c   [STAGES];
    logic             ovf_nx;
    logic             zero_nx;

    // Lookahead temporaries
    logic [K-1:0] grp_g;
    logic [K-1:0] grp_p;
    logic [K:0]   grp_c;
    logic         term;
    logic         carry;
    logic         bit_g;
    logic         bit_p;

    function automatic int bit_pos(input int s, input int j, input int i);
        return (s * K + j) * BLOCK + i;
    endfunction

    assign out_valid = v_q[LAST];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // B is inverted once at entry so later stages only ever add.
    always_comb begin
        st_a[0]   = a;
        st_b[0]   = b ^ {WIDTH{sub}};
        st_sum[0] = '0;
        st_c[0]   = sub | cin;
        st_v[0]   = in_valid;
        st_sub[0] = sub;
        for (int s = 1; s < STAGES; s++) begin
            st_a[s]   = a_q[s-1];
            st_b[s]   = b_q[s-1];
            st_sum[s] = s_q[s-1];
            st_c[s]   = c_q[s-1];
            st_v[s]   = v_q[s-1];
            st_sub[s] = sub_q[s-1];
        end
    end

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        term  = 1'b0;
        carry = 1'b0;
        bit_g = 1'b0;
        bit_p = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            nx_sum[s] = st_sum[s];
            // Group generate/propagate over this stage's groups
            for (int j = 0; j < K; j++) begin
                grp_g[j] = 1'b0;
                grp_p[j] = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    bit_g    = st_a[s][bit_pos(s, j, i)] & st_b[s][bit_pos(s, j, i)];
                    bit_p    = st_a[s][bit_pos(s, j, i)] ^ st_b[s][bit_pos(s, j, i)];
                    grp_g[j] = bit_g | (bit_p & grp_g[j]);
                    grp_p[j] = grp_p[j] & bit_p;
                end
            end
            // Flat sum-of-products group carries from the stage carry-in
            grp_c[0] = st_c[s];
            for (int j = 0; j < K; j++) begin
                term = st_c[s];
                for (int k = 0; k <= j; k++) term = term & grp_p[k];
                carry = term;
                for (int k = 0; k <= j; k++) begin
                    term = grp_g[k];
                    for (int m = k + 1; m <= j; m++) term = term & grp_p[m];
                    carry = carry | term;
                end
                grp_c[j+1] = carry;
            end
            // Sum bits inside each group from its lookahead carry
            for (int j = 0; j < K; j++) begin
                carry = grp_c[j];
                for (int i = 0; i < BLOCK; i++) begin
                    bit_g = st_a[s][bit_pos(s, j, i)] & st_b[s][bit_pos(s, j, i)];
                    bit_p = st_a[s][bit_pos(s, j, i)] ^ st_b[s][bit_pos(s, j, i)];
                    nx_sum[s][bit_pos(s, j, i)] = bit_p ^ carry;
                    carry = bit_g | (bit_p & carry);
                end
            end
            nx_c[s] = grp_c[K];
        end
        // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
        ovf_nx  = nx_sum[LAST][WIDTH-1] ^ st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ nx_c[LAST];
        zero_nx = ~|nx_sum[LAST];
    end

    // Data fields only load with a real beat, so outputs keep their last value across bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]   <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                s_q[s]   <= '0;
                c_q[s]   <= 1'b0;
                sub_q[s] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= st_v[s];
                if (st_v[s]) begin
                    a_q[s]   <= st_a[s];
                    b_q[s]   <= st_b[s];
                    s_q[s]   <= nx_sum[s];
                    c_q[s]   <= nx_c[s];
                    sub_q[s] <= st_sub[s];
                end
            end
            if (st_v[LAST]) begin
                ovf_q  <= ovf_nx;
                zero_q <= zero_nx;
            end
        end
    end
endmodule
